// File: rtl/timer_share_arbiter.sv
// ---------------------------------------------------------------------------
// timer_share_arbiter
//
// Purpose:
//   Shares one hardware timer between N_REQ requesters. Each requester posts
//   a one-shot delay job (prescaler, autoreload) by holding its req bit. The
//   arbiter picks a winner round-robin, programs the timer (clear, then
//   enable), waits for the timer interrupt and pulses done to the owner. The
//   owner can give up early by raising cancel or dropping req, which ends the
//   job with an aborted pulse instead. This block is the only driver of the
//   tim_* control outputs.
//
// Job sequence:  IDLE -> LOAD -> RUN -> DONE -> IDLE
//                               RUN -> ABORT -> IDLE
//                LOAD -> DONE directly when the latched autoreload is zero.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-low reset
//   req            in   [N_REQ]    level request per requester
//   prescaler_in   in   [N_REQ*W]  per-requester prescaler, slice i = [i*W +: W]
//   autoreload_in  in   [N_REQ*W]  per-requester autoreload, slice i = [i*W +: W]
//   cancel         in   [N_REQ]    abort own job while granted
//   gnt            out  [N_REQ]    one-hot owner, zero when idle
//   done           out  [N_REQ]    one-cycle pulse to owner on completion
//   aborted        out  [N_REQ]    one-cycle pulse to owner on cancel/withdraw
//   busy           out            high whenever a job is in progress
//   elapsed        out  [W]        timer count while running, else 0
//   tim_prescaler  out  [W]        timer prescaler
//   tim_autoreload out  [W]        timer autoreload
//   tim_clear      out            synchronous count clear to the timer
//   tim_enable     out            timer count enable
//   tim_mode       out            timer mode, always 0 (one-shot)
//   timer_int      in             timer reached autoreload (one-cycle pulse)
//   tim_count      in   [W]        current timer count
//
// All outputs except the constant tim_mode are registered; their next values
// are derived from the next state so every output lines up with the state it
// belongs to.
// ---------------------------------------------------------------------------
module timer_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] prescaler_in,
  input  logic [N_REQ*W-1:0] autoreload_in,
  input  logic [N_REQ-1:0]   cancel,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   aborted,
  output logic               busy,
  output logic [W-1:0]       elapsed,
  output logic [W-1:0]       tim_prescaler,
  output logic [W-1:0]       tim_autoreload,
  output logic               tim_clear,
  output logic               tim_enable,
  output logic               tim_mode,
  input  logic               timer_int,
  input  logic [W-1:0]       tim_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [W-1:0]     tim_prescaler_q, tim_prescaler_d;
  logic [W-1:0]     tim_autoreload_q, tim_autoreload_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] aborted_q, aborted_d;
  logic             busy_q, busy_d;
  logic [W-1:0]     elapsed_q, elapsed_d;
  logic             tim_clear_q, tim_clear_d;
  logic             tim_enable_q, tim_enable_d;

  // -------------------------------------------------------------------------
  // Unpack the flat per-requester configuration buses
  // -------------------------------------------------------------------------
  logic [W-1:0] psc_slice [N_REQ];
  logic [W-1:0] arr_slice [N_REQ];

  // One-hot form of the next owner, shared by gnt/done/aborted.
  logic [N_REQ-1:0] owner_oh_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign psc_slice[gi]  = prescaler_in[gi*W +: W];
      assign arr_slice[gi]  = autoreload_in[gi*W +: W];
      assign owner_oh_d[gi] = (owner_d == IDX_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin pick: first set req bit at or above rr_q, wrapping around.
  // The loop walks offsets from farthest to nearest so the nearest hit is the
  // last assignment and therefore wins.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [IDX_W:0]   arb_sum;
  logic [IDX_W-1:0] arb_cand;

  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    arb_sum   = '0;
    arb_cand  = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      arb_sum = {1'b0, rr_q} + (IDX_W+1)'(off);
      if (arb_sum >= (IDX_W+1)'(N_REQ)) begin
        arb_sum = arb_sum - (IDX_W+1)'(N_REQ);
      end
      arb_cand = arb_sum[IDX_W-1:0];
      if (req[arb_cand]) begin
        win_valid = 1'b1;
        win_idx   = arb_cand;
      end
    end
  end

  // Pointer value that places the current owner last in the next round.
  logic [IDX_W-1:0] owner_next_rr;
  assign owner_next_rr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_d             = rr_q;
    tim_prescaler_d  = tim_prescaler_q;
    tim_autoreload_d = tim_autoreload_q;

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d          = S_LOAD;
          owner_d          = win_idx;
          // The job's config is captured once here; later changes on the
          // owner's slice do not affect the running job.
          tim_prescaler_d  = psc_slice[win_idx];
          tim_autoreload_d = arr_slice[win_idx];
        end
      end

      S_LOAD: begin
        // A zero-length delay completes without ever enabling the timer.
        if (tim_autoreload_q == '0) begin
          state_d = S_DONE;
          rr_d    = owner_next_rr;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Completion takes priority over a same-cycle cancel/withdraw.
        if (timer_int) begin
          state_d = S_DONE;
          rr_d    = owner_next_rr;
        end else if (cancel[owner_q] || !req[owner_q]) begin
          state_d = S_ABORT;
          rr_d    = owner_next_rr;
        end
      end

      S_DONE, S_ABORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered output values, derived from the state being entered
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_d        = (state_d != S_IDLE) ? owner_oh_d : '0;
    done_d       = (state_d == S_DONE) ? owner_oh_d : '0;
    aborted_d    = (state_d == S_ABORT) ? owner_oh_d : '0;
    busy_d       = (state_d != S_IDLE);
    elapsed_d    = (state_d == S_RUN) ? tim_count : '0;
    // Clear on LOAD so the job starts from zero, and on ABORT so a cancelled
    // count does not linger in the timer.
    tim_clear_d  = (state_d == S_LOAD) || (state_d == S_ABORT);
    tim_enable_d = (state_d == S_RUN);
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      owner_q          <= '0;
      rr_q             <= '0;
      tim_prescaler_q  <= '0;
      tim_autoreload_q <= '0;
      gnt_q            <= '0;
      done_q           <= '0;
      aborted_q        <= '0;
      busy_q           <= 1'b0;
      elapsed_q        <= '0;
      tim_clear_q      <= 1'b0;
      tim_enable_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      rr_q             <= rr_d;
      tim_prescaler_q  <= tim_prescaler_d;
      tim_autoreload_q <= tim_autoreload_d;
      gnt_q            <= gnt_d;
      done_q           <= done_d;
      aborted_q        <= aborted_d;
      busy_q           <= busy_d;
      elapsed_q        <= elapsed_d;
      tim_clear_q      <= tim_clear_d;
      tim_enable_q     <= tim_enable_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign gnt            = gnt_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign busy           = busy_q;
  assign elapsed        = elapsed_q;
  assign tim_prescaler  = tim_prescaler_q;
  assign tim_autoreload = tim_autoreload_q;
  assign tim_clear      = tim_clear_q;
  assign tim_enable     = tim_enable_q;
  assign tim_mode       = 1'b0;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_timer_share_arbiter
//
// Directed bench for timer_share_arbiter (N_REQ=4, W=32). A job-level model
// tracks who owns the timer, how long the job has been held and how it
// ended; a negedge process compares every DUT output against it each cycle.
// Literal expectations in the main sequence pin the model down. A small
// timer stand-in drives tim_count/timer_int from the DUT's clear/enable.
// ---------------------------------------------------------------------------
module tb_timer_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   prescaler_in;
  logic [N*W-1:0]   autoreload_in;
  logic [N-1:0]     cancel;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [N-1:0]     aborted;
  logic             busy;
  logic [W-1:0]     elapsed;
  logic [W-1:0]     tim_prescaler;
  logic [W-1:0]     tim_autoreload;
  logic             tim_clear;
  logic             tim_enable;
  logic             tim_mode;
  logic             timer_int;
  logic [W-1:0]     tim_count;

  int n_checks   = 0;
  int n_failures = 0;

  timer_share_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .prescaler_in   (prescaler_in),
    .autoreload_in  (autoreload_in),
    .cancel         (cancel),
    .gnt            (gnt),
    .done           (done),
    .aborted        (aborted),
    .busy           (busy),
    .elapsed        (elapsed),
    .tim_prescaler  (tim_prescaler),
    .tim_autoreload (tim_autoreload),
    .tim_clear      (tim_clear),
    .tim_enable     (tim_enable),
    .tim_mode       (tim_mode),
    .timer_int      (timer_int),
    .tim_count      (tim_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Job-level model.
  //   owner  : requester holding the timer, -1 when nobody does
  //   age    : 1 in the programming cycle, 2 once the timer is counting
  //   ending : 0 job live, 1 finishing with done, 2 finishing with aborted
  // -------------------------------------------------------------------------
  typedef struct packed {
    int           owner;
    int           age;
    int           ending;
    int           rr;
    logic [W-1:0] psc;
    logic [W-1:0] arr;
    logic [W-1:0] el;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.owner = -1; s.age = 0; s.ending = 0; s.rr = 0;
    s.psc = '0; s.arr = '0; s.el = '0;
    return s;
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic [N-1:0] rq, logic [N-1:0] cn,
                                         logic ti, logic [W-1:0] cnt,
                                         logic [N*W-1:0] pin, logic [N*W-1:0] ain);
    mstate_t n;
    bit found;
    n = s;
    n.el = '0;
    if (s.ending != 0) begin
      // Completion pulse has been shown; the timer is free again.
      n.owner = -1; n.age = 0; n.ending = 0;
    end else if (s.owner < 0) begin
      found = 0;
      for (int off = 0; off < N; off++) begin
        int i;
        i = (s.rr + off) % N;
        if (!found && rq[i]) begin
          found = 1;
          n.owner = i; n.age = 1;
          n.psc = pin[i*W +: W];
          n.arr = ain[i*W +: W];
        end
      end
    end else if (s.age == 1) begin
      if (s.arr == 0) begin
        n.ending = 1; n.rr = (s.owner + 1) % N;
      end else begin
        n.age = 2; n.el = cnt;
      end
    end else begin
      if (ti) begin
        n.ending = 1; n.rr = (s.owner + 1) % N;
      end else if (cn[s.owner] || !rq[s.owner]) begin
        n.ending = 2; n.rr = (s.owner + 1) % N;
      end else begin
        n.el = cnt;
      end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] onehot(int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= model_next(m, req, cancel, timer_int, tim_count, prescaler_in, autoreload_in);
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    logic live;
    live = (m.owner >= 0) && (m.ending == 0);
    chk("gnt",            gnt,            onehot(m.owner));
    chk("busy",           busy,           m.owner >= 0);
    chk("done",           done,           (m.ending == 1) ? onehot(m.owner) : '0);
    chk("aborted",        aborted,        (m.ending == 2) ? onehot(m.owner) : '0);
    chk("tim_clear",      tim_clear,      (live && m.age == 1) || m.ending == 2);
    chk("tim_enable",     tim_enable,     live && m.age == 2);
    chk("tim_prescaler",  tim_prescaler,  m.psc);
    chk("tim_autoreload", tim_autoreload, m.arr);
    chk("elapsed",        elapsed,        m.el);
    chk("tim_mode",       tim_mode,       1'b0);
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers and timer stand-in
  // -------------------------------------------------------------------------
  int env_cnt    = 0;
  int fire_after = 0;   // 0: timer never fires on its own

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (tim_clear)       env_cnt = 0;
    else if (tim_enable) env_cnt++;
    tim_count = W'(env_cnt);
    timer_int = (fire_after > 0 && tim_enable && env_cnt == fire_after);
  endtask

  task automatic set_cfg(input int i, input logic [W-1:0] psc, input logic [W-1:0] arr);
    prescaler_in[i*W +: W]  = psc;
    autoreload_in[i*W +: W] = arr;
  endtask

  task automatic wait_int(input int limit, input string name);
    int k;
    k = 0;
    while (!timer_int && k < limit) begin
      step();
      k++;
    end
    n_checks++;
    if (!timer_int) begin
      n_failures++;
      $display("FAIL %s: timer_int not seen within %0d cycles", name, limit);
    end
  endtask

  function automatic int idx_of(logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  int order[$];
  int exp_order[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    logic [N-1:0] prev_gnt;
    int guard;

    rst = 1'b1; req = '0; cancel = '0; timer_int = 1'b0; tim_count = '0;
    prescaler_in = '0; autoreload_in = '0;
    #1 rst = 1'b0;
    step(); step();
    chk("reset_gnt",  gnt, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_psc",  tim_prescaler, 32'd0);
    rst = 1'b1;
    step();

    // Contention: 0,1,3 held, rr starts at 0.
    for (int i = 0; i < N; i++) set_cfg(i, 32'd2, 32'd3);
    fire_after = 3;
    req = 4'b1011;
    prev_gnt = '0;
    guard = 0;
    while (guard < 300) begin
      step();
      guard++;
      if (gnt != 0 && prev_gnt == 0) order.push_back(idx_of(gnt));
      prev_gnt = gnt;
      if (order.size() == 6 && done != 0) break;
    end
    req = '0;
    chk("contention_grants", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("grant_order", order[i], exp_order[i]);
    step(); step();

    // Single job on requester 0 (rr is back at 0).
    set_cfg(0, 32'd9, 32'd4);
    fire_after = 50;
    req = 4'b0001;
    step();
    chk("single_gnt",       gnt, 4'b0001);
    chk("single_clear",     tim_clear, 1'b1);
    chk("single_enable_ld", tim_enable, 1'b0);
    chk("single_psc",       tim_prescaler, 32'd9);
    chk("single_arr",       tim_autoreload, 32'd4);
    step();
    chk("single_enable",    tim_enable, 1'b1);
    chk("single_clear_off", tim_clear, 1'b0);
    wait_int(100, "single_int");
    step();
    chk("single_done",      done, 4'b0001);
    chk("single_done_gnt",  gnt, 4'b0001);
    chk("single_done_en",   tim_enable, 1'b0);
    req = '0;
    step();
    chk("single_done_once", done, 4'b0000);
    chk("single_idle_gnt",  gnt, 4'b0000);
    chk("single_hold_psc",  tim_prescaler, 32'd9);
    step();

    // Cancel on requester 2 (rr=1 -> scan 1,2,...).
    set_cfg(2, 32'd5, 32'd7);
    fire_after = 0;
    req = 4'b0100;
    step();
    chk("cancel_gnt", gnt, 4'b0100);
    step();
    chk("cancel_enable", tim_enable, 1'b1);
    for (int i = 0; i < 9; i++) step();
    cancel = 4'b0100;
    step();
    chk("cancel_aborted", aborted, 4'b0100);
    chk("cancel_nodone",  done, 4'b0000);
    chk("cancel_enable0", tim_enable, 1'b0);
    chk("cancel_clear",   tim_clear, 1'b1);
    cancel = '0; req = '0;
    step();
    chk("cancel_idle", busy, 1'b0);
    step();

    // Simultaneous timer_int and cancel: done wins (rr=3 -> 3,0,1,2 -> 2).
    fire_after = 5;
    req = 4'b0100;
    step();
    chk("sim_gnt", gnt, 4'b0100);
    wait_int(50, "sim_int");
    cancel = 4'b0100;
    step();
    chk("sim_done",    done, 4'b0100);
    chk("sim_noabort", aborted, 4'b0000);
    cancel = '0; req = '0;
    step(); step();

    // Zero autoreload on requester 1.
    set_cfg(1, 32'd6, 32'd0);
    fire_after = 0;
    req = 4'b0010;
    step();
    chk("zero_gnt",     gnt, 4'b0010);
    chk("zero_en_ld",   tim_enable, 1'b0);
    step();
    chk("zero_done",    done, 4'b0010);
    chk("zero_en_done", tim_enable, 1'b0);
    req = '0;
    step(); step();

    // Withdraw on requester 0 (rr=2 -> 2,3,0 -> 0).
    set_cfg(0, 32'd1, 32'd4);
    req = 4'b0001;
    step(); step(); step(); step();
    chk("wd_running", tim_enable, 1'b1);
    req = '0;
    step();
    chk("wd_aborted", aborted, 4'b0001);
    step();

    // Stray timer_int in IDLE and cancel from a non-owner.
    timer_int = 1'b1;
    cancel = 4'b1000;
    step();
    chk("stray_busy", busy, 1'b0);
    chk("stray_done", done, 4'b0000);
    cancel = '0;
    step();

    // Reset mid-job: rr=1 so requester 3 wins first; after reset 0 wins.
    set_cfg(3, 32'd3, 32'd8);
    req = 4'b1001;
    step();
    chk("rst_pre_gnt", gnt, 4'b1000);
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("rst_async_gnt",    gnt, 4'b0000);
    chk("rst_async_busy",   busy, 1'b0);
    chk("rst_async_enable", tim_enable, 1'b0);
    chk("rst_async_arr",    tim_autoreload, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rst_restart_gnt", gnt, 4'b0001);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_share_arbiter.md
Name: timer_share_arbiter

Overview:
Shares the single hardware timer (prescaler/autoreload/clear/enable/mode, interrupt back) between N_REQ requesters, e.g. the roulette game FSM, display blink logic and LED sweep logic. Each requester posts a one-shot delay job (prescaler, autoreload). The arbiter grants jobs round-robin, programs the timer, waits for its interrupt and returns a done pulse to the owner. Sits between the game-level controllers and the timer peripheral; it is the only driver of the tim_* control outputs.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 32, width of prescaler, autoreload and count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req  in  N_REQ  level request per requester; held until done/aborted
prescaler_in  in  N_REQ*W  per-requester prescaler, slice i = [i*W +: W]
autoreload_in  in  N_REQ*W  per-requester autoreload, slice i = [i*W +: W]
cancel  in  N_REQ  abort own job while granted
gnt  out  N_REQ  one-hot owner, all-zero when idle
done  out  N_REQ  one-cycle pulse to owner on job completion
aborted  out  N_REQ  one-cycle pulse to owner on cancel/withdraw
busy  out  1  high in any state other than IDLE
elapsed  out  W  tim_count while in RUN, else 0
tim_prescaler  out  W  to timer
tim_autoreload  out  W  to timer
tim_clear  out  1  to timer, synchronous count clear
tim_enable  out  1  to timer
tim_mode  out  1  to timer; always 0 (one-shot)
timer_int  in  1  from timer, one-cycle pulse when count reaches autoreload
tim_count  in  W  from timer, current count

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, rr pointer 0, all outputs 0 (gnt, done, aborted, busy, elapsed, tim_* all 0).
- All outputs registered. tim_mode tied 0 at all times.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE; RUN -> ABORT -> IDLE.
- IDLE: if any req bit set, pick the first set bit scanning from rr pointer upward with wrap; next cycle enter LOAD with gnt one-hot for winner k, config latched from slice k. No req: stay.
- LOAD (1 cycle): tim_clear=1, tim_enable=0, tim_prescaler/tim_autoreload = latched values; busy=1. If latched autoreload==0 go directly to DONE (timer not enabled); else RUN.
- RUN: tim_clear=0, tim_enable=1; values held. timer_int=1 -> DONE. cancel[k]=1 or req[k]=0 (without timer_int) -> ABORT. timer_int and cancel in same cycle: DONE wins.
- DONE (1 cycle): done[k]=1, tim_enable=0, gnt still k; next IDLE. rr pointer := (k+1) mod N_REQ.
- ABORT (1 cycle): aborted[k]=1, tim_enable=0, tim_clear=1; next IDLE. rr pointer := (k+1) mod N_REQ.
- IDLE after a job: gnt=0, tim_enable=0, tim_clear=0; tim_prescaler/tim_autoreload hold last values.
- Latency: req rising in IDLE -> gnt and tim_clear at cycle +1 -> tim_enable at +2. timer_int at cycle t -> done at t+1 -> earliest next gnt at t+3.
- Config/requests of non-owners ignored during a job; owner config changes after LOAD ignored.
- Requester holding req after done re-enters arbitration; round-robin guarantees others with pending req are served first.
- cancel[i] for i != owner, or in IDLE: ignored.
- timer_int outside RUN: ignored.
- Reset mid-job: immediate return to IDLE values, timer disabled, no done/aborted pulse.

Test Plan:
- Single job: req[0]=1, prescaler 9, autoreload 4; model timer fires timer_int 50 cycles after enable -> gnt=0001 at +1, tim_clear one cycle, tim_enable until int, done[0] pulse exactly 1 cycle after int, gnt=0 after.
- Contention: req=1011 held continuously, each job autoreload 3 -> grant order 0,1,3,0,1,3; no two gnt bits ever set; tim_enable never high in LOAD.
- Cancel: job on requester 2 running, cancel[2] at enable+10 -> aborted[2]=1 next cycle, no done, tim_enable low, tim_clear pulse; simultaneous timer_int+cancel -> done only.
- Zero autoreload: req[1] with autoreload 0 -> LOAD then DONE, tim_enable never asserted, done[1] at req+2.
- Withdraw/ignore: req[0] dropped in RUN -> aborted[0]; stray timer_int in IDLE and cancel[3] for non-owner -> no state change.
- Reset: assert rst=0 during RUN -> all outputs 0 asynchronously, restart serves pending req from rr pointer 0.
